// File: rtl/merlin_mem_arbiter.sv
// merlin_mem_arbiter
// Shares one memory request/response port between the core instruction port
// and data port. Requests are arbitrated round-robin. The grant is held while a
// request is stalled. A small FIFO of source tags steers the in-order memory
// responses back to the port that issued each request.
//
// Handshake semantics (all ports): a transfer happens on a rising clk_i edge
// where valid & ready & clk_en_i & !reset_i. Once a request is presented it
// keeps its fields stable until accepted. When reset_i=1 or clk_en_i=0, every
// ready/valid output is driven 0.
module merlin_mem_arbiter #(
    parameter int C_OTX_DEPTH_X = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    // instruction port
    output logic        ireqready_o,
    input  logic        ireqvalid_i,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,
    input  logic        irspready_i,
    output logic        irspvalid_o,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,
    // data port
    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqsize_i,
    input  logic        dreqdvalid_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,
    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o,
    // memory port
    input  logic        mreqready_i,
    output logic        mreqvalid_o,
    output logic [1:0]  mreqsize_o,
    output logic        mreqdvalid_o,
    output logic [1:0]  mreqhpl_o,
    output logic [31:0] mreqaddr_o,
    output logic [31:0] mreqdata_o,
    output logic        mrspready_o,
    input  logic        mrspvalid_i,
    input  logic        mrsprerr_i,
    input  logic        mrspwerr_i,
    input  logic [31:0] mrspdata_i
);

    localparam int DEPTH = 1 << C_OTX_DEPTH_X;
    localparam logic [C_OTX_DEPTH_X:0] FULL_COUNT = (C_OTX_DEPTH_X + 1)'(DEPTH);

    // Source encoding shared by the grant, last_grant, lock_src and the tags.
    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

    // Bookkeeping state
    src_t                     last_grant;
    logic                     lock_vld;
    src_t                     lock_src;
    src_t                     tag_mem [DEPTH];
    logic [C_OTX_DEPTH_X-1:0] wr_ptr;
    logic [C_OTX_DEPTH_X-1:0] rd_ptr;
    logic [C_OTX_DEPTH_X:0]   count;

    // Combinational steering
    logic active;
    logic fifo_full;
    logic fifo_empty;
    logic gnt_any;
    src_t gnt;
    logic src_valid;
    src_t head;
    logic push;
    logic pop;

    assign active     = clk_en_i & ~reset_i;
    assign fifo_full  = (count == FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];

    // Arbitration: a held lock wins, then a lone requester, then round-robin.
    always_comb begin
        gnt_any = 1'b0;
        gnt     = SRC_I;
        if (lock_vld) begin
            gnt_any = 1'b1;
            gnt     = lock_src;
        end else if (ireqvalid_i && dreqvalid_i) begin
            gnt_any = 1'b1;
            gnt     = (last_grant == SRC_I) ? SRC_D : SRC_I;
        end else if (dreqvalid_i) begin
            gnt_any = 1'b1;
            gnt     = SRC_D;
        end else if (ireqvalid_i) begin
            gnt_any = 1'b1;
            gnt     = SRC_I;
        end
    end

    // Request path: steer the granted source onto the memory port.
    // A full tag FIFO holds the request back; readies never look at the
    // response side, so a same-cycle pop cannot make room.
    always_comb begin
        src_valid    = (gnt == SRC_D) ? dreqvalid_i : ireqvalid_i;
        mreqvalid_o  = active & gnt_any & src_valid & ~fifo_full;
        ireqready_o  = mreqready_i & mreqvalid_o & (gnt == SRC_I);
        dreqready_o  = mreqready_i & mreqvalid_o & (gnt == SRC_D);
        mreqsize_o   = 2'b10;
        mreqdvalid_o = 1'b0;
        mreqhpl_o    = ireqhpl_i;
        mreqaddr_o   = ireqaddr_i;
        mreqdata_o   = '0;
        if (gnt == SRC_D) begin
            mreqsize_o   = dreqsize_i;
            mreqdvalid_o = dreqdvalid_i;
            mreqhpl_o    = dreqhpl_i;
            mreqaddr_o   = dreqaddr_i;
            mreqdata_o   = dreqdata_i;
        end
    end

    // Response path: the FIFO head decides who sees the response.
    // With nothing outstanding, any response is stalled.
    always_comb begin
        mrspready_o = active & ~fifo_empty &
                      ((head == SRC_D) ? drspready_i : irspready_i);
        irspvalid_o = active & ~fifo_empty & mrspvalid_i & (head == SRC_I);
        drspvalid_o = active & ~fifo_empty & mrspvalid_i & (head == SRC_D);
        irsprerr_o  = mrsprerr_i;
        irspdata_o  = mrspdata_i;
        drsprerr_o  = mrsprerr_i;
        drspwerr_o  = mrspwerr_i;
        drspdata_o  = mrspdata_i;
    end

    assign push = mreqvalid_o & mreqready_i;
    assign pop  = mrspvalid_i & mrspready_o;

    // Grant lock, round-robin history and FIFO pointers; frozen while clk_en_i=0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant <= SRC_I;
            lock_vld   <= 1'b0;
            lock_src   <= SRC_I;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else if (clk_en_i) begin
            lock_vld <= mreqvalid_o & ~mreqready_i;
            if (mreqvalid_o && !mreqready_i) begin
                lock_src <= gnt;
            end
            if (push) begin
                last_grant <= gnt;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage; contents are only meaningful between wr_ptr and rd_ptr.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr] <= gnt;
        end
    end

endmodule

// File: tb/tb_merlin_mem_arbiter.sv
// tb_merlin_mem_arbiter
// Directed bench: reset, contention, lock, response routing, backpressure,
// clock enable and reset with outstanding requests.
module tb_merlin_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, clk_en_i;
  logic        ireqready_o, ireqvalid_i;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        irspready_i, irspvalid_o, irsprerr_o;
  logic [31:0] irspdata_o;
  logic        dreqready_o, dreqvalid_i;
  logic [1:0]  dreqsize_i;
  logic        dreqdvalid_i;
  logic [1:0]  dreqhpl_i;
  logic [31:0] dreqaddr_i, dreqdata_i;
  logic        drspready_i, drspvalid_o, drsprerr_o, drspwerr_o;
  logic [31:0] drspdata_o;
  logic        mreqready_i, mreqvalid_o;
  logic [1:0]  mreqsize_o;
  logic        mreqdvalid_o;
  logic [1:0]  mreqhpl_o;
  logic [31:0] mreqaddr_o, mreqdata_o;
  logic        mrspready_o, mrspvalid_i, mrsprerr_i, mrspwerr_i;
  logic [31:0] mrspdata_i;

  merlin_mem_arbiter #(.C_OTX_DEPTH_X(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i),
    .ireqaddr_i(ireqaddr_i), .irspready_i(irspready_i), .irspvalid_o(irspvalid_o),
    .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
    .dreqready_o(dreqready_o), .dreqvalid_i(dreqvalid_i), .dreqsize_i(dreqsize_i),
    .dreqdvalid_i(dreqdvalid_i), .dreqhpl_i(dreqhpl_i), .dreqaddr_i(dreqaddr_i),
    .dreqdata_i(dreqdata_i), .drspready_i(drspready_i), .drspvalid_o(drspvalid_o),
    .drsprerr_o(drsprerr_o), .drspwerr_o(drspwerr_o), .drspdata_o(drspdata_o),
    .mreqready_i(mreqready_i), .mreqvalid_o(mreqvalid_o), .mreqsize_o(mreqsize_o),
    .mreqdvalid_o(mreqdvalid_o), .mreqhpl_o(mreqhpl_o), .mreqaddr_o(mreqaddr_o),
    .mreqdata_o(mreqdata_o), .mrspready_o(mrspready_o), .mrspvalid_i(mrspvalid_i),
    .mrsprerr_i(mrsprerr_i), .mrspwerr_i(mrspwerr_i), .mrspdata_i(mrspdata_i)
  );

  // ---------------- scoreboard ----------------
  logic exp_q[$];          // expected source tags of outstanding requests (0=I, 1=D)
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Check that the memory port presents a request from src; record a push if accepted.
  task automatic req_chk(input string tag, input logic src);
    check({tag, ".mreqvalid"}, 32'(mreqvalid_o), 32'd1);
    check({tag, ".ireqready"}, 32'(ireqready_o), 32'(mreqready_i & ~src));
    check({tag, ".dreqready"}, 32'(dreqready_o), 32'(mreqready_i & src));
    check({tag, ".addr"}, mreqaddr_o, src ? dreqaddr_i : ireqaddr_i);
    check({tag, ".size"}, 32'(mreqsize_o), src ? 32'(dreqsize_i) : 32'd2);
    check({tag, ".dvalid"}, 32'(mreqdvalid_o), src ? 32'(dreqdvalid_i) : 32'd0);
    check({tag, ".hpl"}, 32'(mreqhpl_o), src ? 32'(dreqhpl_i) : 32'(ireqhpl_i));
    check({tag, ".wdata"}, mreqdata_o, src ? dreqdata_i : 32'd0);
    if (mreqready_i) exp_q.push_back(src);
  endtask

  task automatic no_req_chk(input string tag);
    check({tag, ".mreqvalid"}, 32'(mreqvalid_o), 32'd0);
    check({tag, ".ireqready"}, 32'(ireqready_o), 32'd0);
    check({tag, ".dreqready"}, 32'(dreqready_o), 32'd0);
  endtask

  // Check response steering against the expected head tag; pop if handshake.
  task automatic rsp_chk(input string tag);
    logic hd;
    logic rdy;
    if (exp_q.size() == 0) begin
      check({tag, ".model_empty"}, 32'd0, 32'd1);
    end else begin
      hd  = exp_q[0];
      rdy = hd ? drspready_i : irspready_i;
      check({tag, ".irspvalid"}, 32'(irspvalid_o), 32'(mrspvalid_i & ~hd));
      check({tag, ".drspvalid"}, 32'(drspvalid_o), 32'(mrspvalid_i & hd));
      check({tag, ".mrspready"}, 32'(mrspready_o), 32'(rdy));
      if (hd) begin
        check({tag, ".drspdata"}, drspdata_o, mrspdata_i);
        check({tag, ".drsprerr"}, 32'(drsprerr_o), 32'(mrsprerr_i));
        check({tag, ".drspwerr"}, 32'(drspwerr_o), 32'(mrspwerr_i));
      end else begin
        check({tag, ".irspdata"}, irspdata_o, mrspdata_i);
        check({tag, ".irsprerr"}, 32'(irsprerr_o), 32'(mrsprerr_i));
      end
      if (mrspvalid_i && rdy) void'(exp_q.pop_front());
    end
  endtask

  task automatic set_rsp(input logic v, input logic [31:0] d, input logic re, input logic we);
    mrspvalid_i = v;
    mrspdata_i  = d;
    mrsprerr_i  = re;
    mrspwerr_i  = we;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_i = 1'b1; clk_en_i = 1'b1;
    ireqvalid_i = 1'b1; ireqhpl_i = 2'd3; ireqaddr_i = 32'h0000_1000;
    dreqvalid_i = 1'b1; dreqsize_i = 2'd1; dreqdvalid_i = 1'b1; dreqhpl_i = 2'd1;
    dreqaddr_i = 32'h0000_2000; dreqdata_i = 32'hDEAD_BEEF;
    irspready_i = 1'b1; drspready_i = 1'b1; mreqready_i = 1'b1;
    set_rsp(1'b1, 32'h0, 1'b0, 1'b0);

    // Reset held two cycles with both requesters valid: everything gated.
    for (int i = 0; i < 2; i++) begin
      tick();
      no_req_chk("reset");
      check("reset.mrspready", 32'(mrspready_o), 32'd0);
    end

    // Contention: D,I,D,I then full.
    reset_i = 1'b0;
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      settle();
      req_chk($sformatf("contend%0d", k), (k % 2 == 0));
      tick();
    end
    // Full: pop in the same cycle must not open the request path.
    set_rsp(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    settle();
    no_req_chk("full_with_pop");
    rsp_chk("rsp_d0");
    tick();
    // Push D and pop I in the same cycle (last grant was I).
    set_rsp(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    settle();
    req_chk("push_pop", 1'b1);
    rsp_chk("rsp_i0");
    tick();

    // Responses: queue is D,I,D.
    ireqvalid_i = 1'b0; dreqvalid_i = 1'b0;
    set_rsp(1'b1, 32'h3333_3333, 1'b0, 1'b1);
    settle();
    rsp_chk("rsp_d1");
    tick();
    // Backpressure at head I.
    irspready_i = 1'b0;
    set_rsp(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      rsp_chk("bp");
      tick();
    end
    irspready_i = 1'b1;
    set_rsp(1'b1, 32'hAAAA_0000, 1'b0, 1'b0);
    settle();
    rsp_chk("rsp_i1");
    check("rsp_i1.data_const", irspdata_o, 32'hAAAA_0000);
    tick();
    set_rsp(1'b1, 32'h0000_5555, 1'b1, 1'b0);
    settle();
    rsp_chk("rsp_d2");
    check("rsp_d2.data_const", drspdata_o, 32'h0000_5555);
    check("rsp_d2.rerr_const", 32'(drsprerr_o), 32'd1);
    tick();
    // Empty FIFO: unsolicited response stalls.
    set_rsp(1'b1, 32'h7777_7777, 1'b0, 1'b0);
    settle();
    check("empty.mrspready", 32'(mrspready_o), 32'd0);
    check("empty.irspvalid", 32'(irspvalid_o), 32'd0);
    check("empty.drspvalid", 32'(drspvalid_o), 32'd0);
    tick();
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);

    // Lone I request so that last grant becomes I.
    ireqvalid_i = 1'b1;
    settle();
    req_chk("lone_i", 1'b0);
    tick();

    // Lock on D at 0x100 while I waits.
    dreqvalid_i = 1'b1; dreqaddr_i = 32'h0000_0100; mreqready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      req_chk($sformatf("lock_d%0d", i), 1'b1);
      tick();
    end
    mreqready_i = 1'b1;
    settle();
    req_chk("lock_d_acc", 1'b1);
    tick();
    settle();
    req_chk("after_lock_i", 1'b0);
    tick();

    // Lock on I (lone requester), then D arrives: round-robin would pick D.
    dreqvalid_i = 1'b0; mreqready_i = 1'b0;
    settle();
    req_chk("lock_i0", 1'b0);
    tick();
    dreqvalid_i = 1'b1;
    settle();
    req_chk("lock_i1", 1'b0);
    tick();
    // Clock enable low while locked: all gated, nothing moves.
    clk_en_i = 1'b0; mreqready_i = 1'b1;
    set_rsp(1'b1, 32'h4444_4444, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      settle();
      no_req_chk("clken");
      check("clken.mrspready", 32'(mrspready_o), 32'd0);
      check("clken.irspvalid", 32'(irspvalid_o), 32'd0);
      tick();
    end
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    clk_en_i = 1'b1;
    settle();
    req_chk("lock_i_resume", 1'b0);
    tick();
    // Four outstanding (I,D,I,I): full again.
    settle();
    no_req_chk("full2");
    tick();
    ireqvalid_i = 1'b0; dreqvalid_i = 1'b0;

    // Drain two (pointers have wrapped).
    set_rsp(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    settle();
    rsp_chk("wrap_i");
    tick();
    set_rsp(1'b1, 32'h0000_0002, 1'b0, 1'b1);
    settle();
    rsp_chk("wrap_d");
    tick();

    // Reset with two requests outstanding: their responses are stalled.
    reset_i = 1'b1;
    set_rsp(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    set_rsp(1'b1, 32'h0000_0003, 1'b0, 1'b0);
    ireqvalid_i = 1'b1; dreqvalid_i = 1'b1;
    settle();
    check("post_reset.mrspready", 32'(mrspready_o), 32'd0);
    check("post_reset.irspvalid", 32'(irspvalid_o), 32'd0);
    req_chk("post_reset_d", 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
